// File: rtl/wir_ctrl.sv
// Wrapper instruction register controller: serial WIR with shift/update stages,
// instruction decode to boundary-cell controls, a one-bit bypass, and wso steering.
module wir_ctrl #(
  parameter logic [2:0] WIR_CAPTURE = 3'b001
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       wsi,
  input  logic       select_wir,
  input  logic       shift_wr,
  input  logic       capture_wr,
  input  logic       update_wr,
  input  logic       wbr_so,
  output logic       wso,
  output logic       cell_shift,
  output logic       cell_capture,
  output logic       cell_update,
  output logic       cell_mode,
  output logic       cell_safe,
  output logic       cell_io_face,
  output logic [2:0] wir_out,
  output logic       ctl_err
);

  typedef enum logic [2:0] {
    I_BYPASS  = 3'b000,
    I_EXTEST  = 3'b001,
    I_INTEST  = 3'b010,
    I_SAFE    = 3'b011,
    I_PRELOAD = 3'b100,
    I_CLAMP   = 3'b101
  } instr_t;

  logic [2:0] wir_shift;
  logic [2:0] wir_active;
  logic       wby;
  logic       wbr_sel;

  // Only one request acts per cycle: capture beats shift beats update.
  logic cap_win;
  logic shf_win;
  logic upd_win;
  logic multi_req;

  assign cap_win   = capture_wr;
  assign shf_win   = shift_wr & ~capture_wr;
  assign upd_win   = update_wr & ~capture_wr & ~shift_wr;
  assign multi_req = (shift_wr & capture_wr) | (shift_wr & update_wr) |
                     (capture_wr & update_wr);

  // Decode of the active instruction; 110/111 fall into the BYPASS default.
  always_comb begin
    wbr_sel      = 1'b0;
    cell_mode    = 1'b0;
    cell_safe    = 1'b0;
    cell_io_face = 1'b0;
    case (wir_active)
      I_EXTEST: begin
        wbr_sel   = 1'b1;
        cell_mode = 1'b1;
      end
      I_INTEST: begin
        wbr_sel      = 1'b1;
        cell_mode    = 1'b1;
        cell_io_face = 1'b1;
      end
      I_PRELOAD: begin
        wbr_sel = 1'b1;
      end
      I_SAFE: begin
        cell_mode = 1'b1;
        cell_safe = 1'b1;
      end
      I_CLAMP: begin
        cell_mode = 1'b1;
      end
      default: begin
        wbr_sel = 1'b0;
      end
    endcase
  end

  always_comb begin
    cell_shift   = 1'b0;
    cell_capture = 1'b0;
    cell_update  = 1'b0;
    if (!select_wir && wbr_sel) begin
      cell_shift   = shf_win;
      cell_capture = cap_win;
      cell_update  = upd_win;
    end
  end

  always_comb begin
    if (select_wir)   wso = wir_shift[0];
    else if (wbr_sel) wso = wbr_so;
    else              wso = wby;
  end

  assign wir_out = wir_active;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wir_shift  <= 3'b000;
      wir_active <= I_BYPASS;
      wby        <= 1'b0;
      ctl_err    <= 1'b0;
    end else begin
      if (multi_req) ctl_err <= 1'b1;
      if (select_wir) begin
        if (cap_win)      wir_shift  <= WIR_CAPTURE;
        else if (shf_win) wir_shift  <= {wsi, wir_shift[2:1]};
        else if (upd_win) wir_active <= wir_shift;
      end else if (!wbr_sel) begin
        if (cap_win)      wby <= 1'b0;
        else if (shf_win) wby <= wsi;
      end
    end
  end

endmodule

// File: tb/tb_wir_ctrl.sv
// Directed bench for wir_ctrl: instruction loads, capture/readout, bypass,
// decode of each instruction, illegal control and asynchronous reset.
module tb_wir_ctrl;

  logic       clk = 1'b0;
  logic       arst;
  logic       wsi, select_wir, shift_wr, capture_wr, update_wr, wbr_so;
  logic       wso, cell_shift, cell_capture, cell_update;
  logic       cell_mode, cell_safe, cell_io_face, ctl_err;
  logic [2:0] wir_out;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  wir_ctrl #(.WIR_CAPTURE(3'b001)) dut (
    .clk(clk), .arst(arst), .wsi(wsi), .select_wir(select_wir),
    .shift_wr(shift_wr), .capture_wr(capture_wr), .update_wr(update_wr),
    .wbr_so(wbr_so), .wso(wso), .cell_shift(cell_shift),
    .cell_capture(cell_capture), .cell_update(cell_update),
    .cell_mode(cell_mode), .cell_safe(cell_safe), .cell_io_face(cell_io_face),
    .wir_out(wir_out), .ctl_err(ctl_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wso(input string tag);
    logic [0:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {7'b0, wso}, {7'b0, e});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wsi = 0; shift_wr = 0; capture_wr = 0; update_wr = 0;
  endtask

  // Shift an instruction in LSB first, then update it into the active stage.
  task automatic load_instr(input logic [2:0] ins);
    idle_inputs();
    select_wir = 1;
    shift_wr   = 1;
    for (int i = 0; i < 3; i++) begin
      wsi = ins[i];
      tick();
    end
    shift_wr  = 0;
    wsi       = 0;
    update_wr = 1;
    tick();
    update_wr = 0;
    #1;
  endtask

  task automatic chk_decode(input string tag, input logic [2:0] w,
                            input logic m, input logic s, input logic f);
    chk({tag, "_wir_out"}, {5'b0, wir_out}, {5'b0, w});
    chk({tag, "_mode"}, {7'b0, cell_mode}, {7'b0, m});
    chk({tag, "_safe"}, {7'b0, cell_safe}, {7'b0, s});
    chk({tag, "_io_face"}, {7'b0, cell_io_face}, {7'b0, f});
  endtask

  initial begin
    arst = 1; select_wir = 0; wbr_so = 0;
    idle_inputs();
    #3;
    chk_decode("rst", 3'b000, 0, 0, 0);
    chk("rst_cell_shift", {7'b0, cell_shift}, 8'h0);
    chk("rst_wso", {7'b0, wso}, 8'h0);
    chk("rst_ctl_err", {7'b0, ctl_err}, 8'h0);
    tick();
    arst = 0;
    tick();

    // Load EXTEST and drive the boundary chain.
    load_instr(3'b001);
    chk_decode("extest", 3'b001, 1, 0, 0);
    select_wir = 0; shift_wr = 1; wbr_so = 1;
    #1;
    chk("extest_cell_shift", {7'b0, cell_shift}, 8'h1);
    chk("extest_cell_capture", {7'b0, cell_capture}, 8'h0);
    chk("extest_wso_hi", {7'b0, wso}, 8'h1);
    wbr_so = 0;
    #1;
    chk("extest_wso_lo", {7'b0, wso}, 8'h0);
    shift_wr = 0; update_wr = 1;
    #1;
    chk("extest_cell_update", {7'b0, cell_update}, 8'h1);
    tick();
    update_wr = 0;
    chk("data_update_keeps_wir", {5'b0, wir_out}, 8'h01);

    // WIR capture then readout, LSB first.
    select_wir = 1; capture_wr = 1;
    tick();
    capture_wr = 0; shift_wr = 1; wsi = 0;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_wso("wir_readout");
      tick();
    end
    shift_wr = 0;
    chk("capture_keeps_wir", {5'b0, wir_out}, 8'h01);

    // Reset in the middle of shifting a new instruction.
    shift_wr = 1; wsi = 1;
    tick();
    #2;
    arst = 1;
    #1;
    chk_decode("midshift_rst", 3'b000, 0, 0, 0);
    select_wir = 0;
    #1;
    chk("midshift_rst_wso", {7'b0, wso}, 8'h0);
    chk("midshift_rst_cell_shift", {7'b0, cell_shift}, 8'h0);
    tick();
    arst = 0;
    idle_inputs();
    select_wir = 1; capture_wr = 1;
    tick();
    capture_wr = 0;
    #1;
    chk("post_rst_capture_wso", {7'b0, wso}, 8'h1);

    // Unused encoding 111 acts as BYPASS through WBY.
    load_instr(3'b111);
    chk_decode("op111", 3'b111, 0, 0, 0);
    select_wir = 0; shift_wr = 1;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    wsi = 1; #1; chk_wso("bypass_wso"); chk("bypass_cell_shift", {7'b0, cell_shift}, 8'h0); tick();
    wsi = 0; #1; chk_wso("bypass_wso"); chk("bypass_cell_shift", {7'b0, cell_shift}, 8'h0); tick();
    wsi = 1; #1; chk_wso("bypass_wso"); chk("bypass_cell_shift", {7'b0, cell_shift}, 8'h0); tick();
    wsi = 0; #1; chk_wso("bypass_wso");
    shift_wr = 0; capture_wr = 1;
    tick();
    capture_wr = 0;
    #1;
    chk("bypass_capture_wso", {7'b0, wso}, 8'h0);

    // SAFE, then INTEST.
    load_instr(3'b011);
    chk_decode("safe", 3'b011, 1, 1, 0);
    select_wir = 0; shift_wr = 1;
    #1;
    chk("safe_wby_cell_shift", {7'b0, cell_shift}, 8'h0);
    load_instr(3'b010);
    chk_decode("intest", 3'b010, 1, 0, 1);

    // CLAMP selects WBY, PRELOAD selects WBR.
    load_instr(3'b101);
    chk_decode("clamp", 3'b101, 1, 0, 0);
    select_wir = 0; shift_wr = 1;
    #1;
    chk("clamp_cell_shift", {7'b0, cell_shift}, 8'h0);
    load_instr(3'b100);
    chk_decode("preload", 3'b100, 0, 0, 0);
    select_wir = 0; shift_wr = 1;
    #1;
    chk("preload_cell_shift", {7'b0, cell_shift}, 8'h1);
    chk("no_err_yet", {7'b0, ctl_err}, 8'h0);

    // Illegal control: shift and capture together on the boundary chain.
    capture_wr = 1;
    #1;
    chk("illegal_cell_capture", {7'b0, cell_capture}, 8'h1);
    chk("illegal_cell_shift", {7'b0, cell_shift}, 8'h0);
    chk("illegal_err_before_edge", {7'b0, ctl_err}, 8'h0);
    tick();
    idle_inputs();
    #1;
    chk("illegal_err_set", {7'b0, ctl_err}, 8'h1);
    select_wir = 1; shift_wr = 1; update_wr = 1;
    tick();
    idle_inputs();
    chk("shift_beats_update", {5'b0, wir_out}, 8'h04);
    tick();
    chk("illegal_err_sticky", {7'b0, ctl_err}, 8'h1);
    #2;
    arst = 1;
    #1;
    chk("illegal_err_cleared", {7'b0, ctl_err}, 8'h0);
    chk("final_rst_wir_out", {5'b0, wir_out}, 8'h00);
    tick();
    arst = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wir_ctrl.md
WIR_CTRL -- requirements
Module: wir_ctrl

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  wrapper clock (WRCK); all state on rising edge.
  arst  in  1  reset, asynchronous, active-high.
  wsi  in  1  wrapper serial input.
  select_wir  in  1  1 = WIR path selected; 0 = data path (WBR/WBY).
  shift_wr  in  1  shift request.
  capture_wr  in  1  capture request.
  update_wr  in  1  update request.
  wbr_so  in  1  serial out of the boundary-cell chain.
  wso  out  1  wrapper serial output.
  cell_shift  out  1  shift to boundary cells.
  cell_capture  out  1  capture to boundary cells.
  cell_update  out  1  update to boundary cells.
  cell_mode  out  1  mode to boundary cells.
  cell_safe  out  1  safe to boundary cells.
  cell_io_face  out  1  0 = outward (EXTEST), 1 = inward (INTEST).
  wir_out  out  3  active instruction.
  ctl_err  out  1  sticky illegal-control flag.
REQ-002 SHALL have parameters, one per line: name, default, meaning.
  WIR_CAPTURE, 3'b001, value loaded into the WIR shift stage on capture.

Function
REQ-003 SHALL hold a 3-bit WIR shift stage, a 3-bit WIR active (update) stage, and a 1-bit bypass register (WBY).
REQ-004 SHALL use these instruction encodings:
  BYPASS=000, EXTEST=001, INTEST=010, SAFE=011, PRELOAD=100, CLAMP=101.
  110 and 111 SHALL decode as BYPASS.
REQ-005 With select_wir=1 and shift_wr=1, the WIR shift stage SHALL load {wsi, shift[2:1]} each clock.
REQ-006 With select_wir=1 and capture_wr=1, the WIR shift stage SHALL load WIR_CAPTURE.
REQ-007 With select_wir=1 and update_wr=1, the active stage SHALL load the shift stage.
  The new instruction is visible on wir_out and on the decoded outputs the cycle after the edge.
REQ-008 The active stage SHALL change only per REQ-007 or on reset.
REQ-009 Decode SHALL select the data register and drive cell_mode / cell_safe / cell_io_face as follows:
  EXTEST: WBR, 1/0/0.
  INTEST: WBR, 1/0/1.
  PRELOAD: WBR, 0/0/0.
  SAFE: WBY, 1/1/0.
  CLAMP: WBY, 1/0/0.
  BYPASS: WBY, 0/0/0.
REQ-010 With select_wir=0 and WBR selected: cell_shift=shift_wr, cell_capture=capture_wr, cell_update=update_wr. Otherwise these three SHALL be 0.
REQ-011 With select_wir=0 and WBY selected:
  shift_wr=1 -> WBY <= wsi.
  capture_wr=1 -> WBY <= 0.
  Otherwise WBY holds.
REQ-012 wso SHALL be combinational:
  select_wir=1 -> WIR shift[0].
  else WBR selected -> wbr_so.
  else -> WBY.
REQ-013 If more than one of shift_wr/capture_wr/update_wr is high in a cycle:
  capture > shift > update priority for internal state, and only the winner SHALL propagate to cell_* outputs.
  ctl_err SHALL set on the next edge and stay set until reset.
REQ-014 Changing select_wir between cycles SHALL be legal and SHALL NOT corrupt the WIR active stage.

Reset
REQ-015 arst=1 SHALL immediately force:
  WIR shift = 000, WIR active = BYPASS, WBY = 0, ctl_err = 0.
  Hence wir_out=000, cell_mode=0, cell_safe=0, cell_io_face=0, cell_shift/capture/update=0.
REQ-016 arst asserted mid-shift or mid-update SHALL discard the partial instruction. The first post-reset clock SHALL act on inputs normally.

Verification
REQ-017 Reset: assert arst during an EXTEST shift -> wir_out=000, all cell_* = 0, wso=WBY=0.
REQ-018 Load EXTEST: select_wir=1, shift wsi bits 1,0,0 (3 clocks), update -> wir_out=001, cell_mode=1, cell_io_face=0. Then select_wir=0, shift_wr=1 -> cell_shift=1, wso=wbr_so.
REQ-019 WIR capture/readout: capture then 3 shifts -> wso sequence 1,0,0 (WIR_CAPTURE=001, LSB first).
REQ-020 Bypass: instruction 111, select_wir=0, shift wsi=1,0,1 -> wso=0,1,0,1 (one-cycle delay). cell_shift stays 0 throughout.
REQ-021 SAFE: load 011 -> cell_safe=1, cell_mode=1, WBY selected. Load 010 next -> cell_safe=0, cell_io_face=1.
REQ-022 Illegal control: shift_wr=capture_wr=1 with WBR selected -> cell_capture=1, cell_shift=0, ctl_err=1 from the next cycle until arst.
